// File: rtl/merge_rr_pkg.sv
// merge_rr_pkg: shared definitions for the merge_rr round-robin arbiter.
//   - state_t        : arbiter FSM encoding (IDLE=1'b0, BUSY=1'b1)
//   - TMO_CNT_W      : width of the optional transaction timeout counter
//   - wrap_inc()     : index increment modulo a master count
package merge_rr_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int TMO_CNT_W = 16;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/merge_rr_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
// Ports:
//   valid [N-1:0]  request vector
//   ptr            highest-priority index for this search
//   idx            first set index found searching ptr, ptr+1, ... modulo N
//   found          1 when any valid bit is set
module rr_pick #(
    parameter int N = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] j;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!found && valid[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/merge_rr.sv
// merge_rr: sequential round-robin arbiter sharing one native-bus slave
// between N_MASTERS masters. The grant is locked from arbitration until the
// slave answers with ready (or the granted master withdraws its request).
//
// Bus formats: request = {valid, addr, wdata, wstrb} (valid at MSB),
//              response = {rdata, ready}.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   m_req     N_MASTERS concatenated master requests (master i at slice i)
//   m_resp    N_MASTERS concatenated master responses (master i at slice i)
//   s_req     request forwarded to the shared slave
//   s_resp    slave response
//   grant     registered index of the owning master
//   busy      registered, high while a transaction is in progress
//   err       (MERGE_RR_TIMEOUT_EN only) one-cycle pulse on a slave timeout
//
// Optional feature: define MERGE_RR_TIMEOUT_EN to add parameter TIMEOUT and
// port err. A transaction still waiting for ready on its TIMEOUT-th BUSY
// cycle is completed locally with rdata all-ones.
module merge_rr
    import merge_rr_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
`ifdef MERGE_RR_TIMEOUT_EN
    parameter int TIMEOUT   = 255,
`endif
    localparam int REQ_W    = 1 + ADDR_W + DATA_W + DATA_W / 8,
    localparam int RESP_W   = DATA_W + 1,
    localparam int GW       = $clog2(N_MASTERS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [GW-1:0]               grant,
    output logic                        busy
`ifdef MERGE_RR_TIMEOUT_EN
    ,
    output logic                        err
`endif
);

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic            busy_q, busy_d;

    logic [N_MASTERS-1:0] vld_vec;
    logic [GW-1:0]        pick_idx;
    logic                 pick_found;
    logic [GW-1:0]        ptr_inc;
    logic [REQ_W-1:0]     g_req;
    logic                 g_vld;
    logic                 s_ready;

`ifdef MERGE_RR_TIMEOUT_EN
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT - 1);
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
    // err_q marks the BUSY cycle in which the timeout response is issued,
    // which keeps err a plain register output.
    logic                 err_q, err_d;
`endif

    always_comb begin
        vld_vec = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            vld_vec[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    rr_pick #(.N(N_MASTERS)) u_pick (
        .valid (vld_vec),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign g_req   = m_req[int'(grant_q)*REQ_W +: REQ_W];
    assign g_vld   = g_req[REQ_W-1];
    assign s_ready = s_resp[0];
    assign ptr_inc = GW'(wrap_inc(int'(grant_q), N_MASTERS));

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        s_req   = '0;
        m_resp  = '0;
`ifdef MERGE_RR_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = ST_BUSY;
`ifdef MERGE_RR_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = (TMO_LAST == '0);
`endif
                end
            end
            ST_BUSY: begin
                m_resp[int'(grant_q)*RESP_W +: RESP_W] = s_resp;
`ifdef MERGE_RR_TIMEOUT_EN
                if (err_q) begin
                    // Slave never answered: complete locally, keep it off the bus.
                    m_resp[int'(grant_q)*RESP_W +: RESP_W] = {{DATA_W{1'b1}}, 1'b1};
                    ptr_d   = ptr_inc;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else
`endif
                if (!g_vld) begin
                    // Owner withdrew before ready: abort without forwarding.
                    ptr_d   = ptr_inc;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    s_req = g_req;
                    if (s_ready) begin
                        ptr_d   = ptr_inc;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
`ifdef MERGE_RR_TIMEOUT_EN
                    else begin
                        cnt_d = cnt_q + 1'b1;
                        err_d = (cnt_q + 1'b1 == TMO_LAST);
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
`ifdef MERGE_RR_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
`ifdef MERGE_RR_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
`ifdef MERGE_RR_TIMEOUT_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_merge_rr.sv
// tb_merge_rr: self-checking bench for merge_rr with four masters.
// A transaction-level reference (owner, priority pointer, busy-cycle count)
// predicts s_req, m_resp, busy, grant (and err with MERGE_RR_TIMEOUT_EN)
// every cycle; directed scenarios add literal expectations.
module tb_merge_rr;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RQ = 1 + AW + DW + DW / 8;
    localparam int RS = DW + 1;
`ifdef MERGE_RR_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N*RQ-1:0] m_req;
    logic [N*RS-1:0] m_resp;
    logic [RQ-1:0]   s_req;
    logic [RS-1:0]   s_resp;
    logic [1:0]      grant;
    logic            busy;
`ifdef MERGE_RR_TIMEOUT_EN
    logic            err;
    logic            obs_err;
`endif

    logic        mv[N];
    logic [31:0] ma[N];
    logic [31:0] md[N];
    logic [3:0]  ms[N];
    bit          rereq[N];
    logic        s_rdy;
    logic [31:0] s_rdata;

    assign s_resp = {s_rdata, s_rdy};

    always_comb begin
        m_req = '0;
        for (int i = 0; i < N; i++) m_req[i*RQ +: RQ] = {mv[i], ma[i], md[i], ms[i]};
    end

    always #5 clk = ~clk;

    merge_rr #(
        .N_MASTERS (N),
        .DATA_W    (DW),
        .ADDR_W    (AW)
`ifdef MERGE_RR_TIMEOUT_EN
        ,
        .TIMEOUT   (TMO)
`endif
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp),
        .grant  (grant),
        .busy   (busy)
`ifdef MERGE_RR_TIMEOUT_EN
        ,
        .err    (err)
`endif
    );

    int total = 0;
    int bad   = 0;
    int lat;
    bit rnd;
    int scnt;

    // reference state
    int own;
    int mptr;
    int mgrant;
    int mbcnt;

    logic            obs_busy;
    logic [1:0]      obs_grant;
    logic [RQ-1:0]   obs_sreq;
    logic [N*RS-1:0] obs_resp;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic new_req(input int i);
        mv[i] = 1'b1;
        ma[i] = $urandom;
        md[i] = $urandom;
        ms[i] = 4'($urandom);
    endtask

    task automatic slave_drive();
        #1;
        if (s_req[RQ-1]) begin
            scnt++;
            s_rdy = (lat == 0) ? ($urandom_range(0, 99) < 40) : (scnt >= lat);
        end else begin
            scnt  = 0;
            s_rdy = (lat == 0) ? ($urandom_range(0, 99) < 20) : 1'b0;
        end
        s_rdata = (lat == 0) ? $urandom : 32'h1234_5678;
    endtask

    task automatic cycle();
        logic [RQ-1:0]   es;
        logic [N*RS-1:0] em;
        logic            eb;
        logic [1:0]      eg;
        bit              done;
`ifdef MERGE_RR_TIMEOUT_EN
        logic            ee;
        ee = 1'b0;
`endif
        slave_drive();
        @(negedge clk);
        es = '0;
        em = '0;
        eb = 1'b0;
        eg = 2'(mgrant);
        if (own >= 0) begin
            eb = 1'b1;
            eg = 2'(own);
            if (TMO > 0 && mbcnt == TMO) begin
                em[own*RS +: RS] = {32'hFFFF_FFFF, 1'b1};
`ifdef MERGE_RR_TIMEOUT_EN
                ee = 1'b1;
`endif
            end else begin
                em[own*RS +: RS] = s_resp;
                if (mv[own]) es = {mv[own], ma[own], md[own], ms[own]};
            end
        end
        chk("s_req", s_req, es);
        chk("m_resp", m_resp, em);
        chk("busy", busy, eb);
        chk("grant", grant, eg);
`ifdef MERGE_RR_TIMEOUT_EN
        chk("err", err, ee);
        obs_err = err;
`endif
        obs_busy  = busy;
        obs_grant = grant;
        obs_sreq  = s_req;
        obs_resp  = m_resp;
        // advance the reference on the coming edge
        if (own < 0) begin
            for (int k = 0; k < N; k++) begin
                if (own < 0 && mv[(mptr + k) % N]) begin
                    own    = (mptr + k) % N;
                    mgrant = own;
                    mbcnt  = 1;
                end
            end
        end else begin
            done = (TMO > 0 && mbcnt == TMO) || !mv[own] || s_rdy;
            if (done) begin
                mptr = (own + 1) % N;
                own  = -1;
            end else begin
                mbcnt++;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (mv[i] && obs_resp[i*RS]) begin
                if (rereq[i] || (rnd && $urandom_range(0, 1) == 1)) new_req(i);
                else mv[i] = 1'b0;
            end
        end
        if (rnd) begin
            for (int i = 0; i < N; i++) begin
                if (!mv[i] && $urandom_range(0, 99) < 30) new_req(i);
            end
        end
    endtask

    task automatic model_reset();
        own    = -1;
        mptr   = 0;
        mgrant = 0;
        mbcnt  = 0;
        scnt   = 0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        rnd     = 1'b0;
        lat     = 1;
        s_rdy   = 1'b0;
        s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; ma[i] = '0; md[i] = '0; ms[i] = '0; rereq[i] = 1'b0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, first, rdyc, gn, prevb, iso_bad, tc;
        bit gr_ok, m1done, got, seen;
        logic [RQ-1:0] sreq1;
        logic [31:0]   rd0;
        int gseq[8];
        int gcyc[8];

        // reset state, with a master already requesting
        rst = 1'b1; lat = 1; rnd = 1'b0; scnt = 0; s_rdy = 1'b0; s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; ma[i] = '0; md[i] = '0; ms[i] = '0; rereq[i] = 1'b0;
        end
        mv[0] = 1'b1; ma[0] = 32'h55;
        model_reset();
        @(posedge clk); #2;
        chk("rst_busy0", busy, 1'b0);
        chk("rst_grant0", grant, 2'd0);
        chk("rst_sreq0", s_req, '0);
        chk("rst_mresp0", m_resp, '0);

        // single master, slave answers on the 4th cycle of the request
        do_reset();
        lat = 4;
        mv[0] = 1'b1; ma[0] = 32'h10; md[0] = 32'hA5A5_A5A5; ms[0] = 4'hF;
        nb = 0; first = -1; rdyc = -1; gr_ok = 1'b1; sreq1 = '0; rd0 = '0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (obs_busy) begin
                nb++;
                if (first < 0) begin first = c; sreq1 = obs_sreq; end
                if (obs_grant != 2'd0) gr_ok = 1'b0;
            end
            if (obs_resp[0] && rdyc < 0) begin rdyc = c; rd0 = obs_resp[32:1]; end
        end
        chk("sm_first_busy", first, 1);
        chk("sm_sreq", sreq1, {1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF});
        chk("sm_busy_cycles", nb, 4);
        chk("sm_ready_cycle", rdyc, 4);
        chk("sm_rdata", rd0, 32'h1234_5678);
        chk("sm_grant", gr_ok, 1'b1);

        // contention: all four at once, single-cycle slave
        do_reset();
        lat = 1;
        for (int i = 0; i < N; i++) new_req(i);
        gn = 0;
        for (int c = 0; c < 14; c++) begin
            cycle();
            if (obs_busy && gn < 8) begin gseq[gn] = obs_grant; gcyc[gn] = c; gn++; end
        end
        chk("ct_count", gn, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ct_grant%0d", k), gseq[k], k);
            chk($sformatf("ct_cycle%0d", k), gcyc[k], 1 + 2 * k);
        end
        new_req(3);
        new_req(0);
        cycle();
        cycle();
        chk("ct_wrap_busy", obs_busy, 1'b1);
        chk("ct_wrap_grant", obs_grant, 2'd0);
        for (int c = 0; c < 8; c++) cycle();

        // fairness: m1 keeps re-requesting, m2 asks once
        do_reset();
        lat = 2;
        new_req(1); rereq[1] = 1'b1;
        new_req(2);
        gn = 0; prevb = 0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            if (obs_busy && prevb == 0 && gn < 8) begin gseq[gn] = obs_grant; gn++; end
            prevb = obs_busy ? 1 : 0;
        end
        chk("fr_grant0", gseq[0], 1);
        chk("fr_grant1", gseq[1], 2);
        chk("fr_grant2", gseq[2], 1);
        rereq[1] = 1'b0;
        for (int c = 0; c < 10; c++) cycle();

        // isolation: m0 arrives while m1 owns the slave
        do_reset();
        lat = 3;
        mv[1] = 1'b1; ma[1] = 32'h40; md[1] = 32'h1; ms[1] = 4'hF;
        cycle();
        mv[0] = 1'b1; ma[0] = 32'h20; md[0] = 32'h2; ms[0] = 4'hF;
        iso_bad = 0; m1done = 1'b0;
        for (int c = 0; c < 10 && !m1done; c++) begin
            cycle();
            if (obs_busy && obs_grant == 2'd1) begin
                if (obs_resp[RS-1:0] != '0) iso_bad++;
                if (obs_sreq[RQ-1] && obs_sreq[RQ-2 -: 32] == 32'h20) iso_bad++;
                if (obs_resp[RS]) m1done = 1'b1;
            end
        end
        chk("iso_m1_done", m1done, 1'b1);
        chk("iso_leak", iso_bad, 0);
        seen = 1'b0;
        for (int c = 0; c < 4 && !seen; c++) begin
            cycle();
            if (obs_busy) begin
                seen = 1'b1;
                chk("iso_next_grant", obs_grant, 2'd0);
                chk("iso_next_addr", obs_sreq[RQ-2 -: 32], 32'h20);
            end
        end
        chk("iso_next_seen", seen, 1'b1);
        for (int c = 0; c < 8; c++) cycle();

        // reset in the middle of m2's transaction
        do_reset();
        lat = 1000;
        new_req(2);
        cycle(); cycle(); cycle();
        chk("rb_was_busy", obs_busy, 1'b1);
        rst = 1'b1;
        #2;
        chk("rb_busy", busy, 1'b0);
        chk("rb_grant", grant, 2'd0);
        chk("rb_sreq", s_req, '0);
        chk("rb_m2_resp", m_resp[2*RS +: RS], '0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        lat = 2;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            cycle();
            if (obs_resp[2*RS]) got = 1'b1;
        end
        chk("rb_served_after", got, 1'b1);
        for (int c = 0; c < 4; c++) cycle();

`ifdef MERGE_RR_TIMEOUT_EN
        // slave never answers
        do_reset();
        lat = 100000;
        new_req(0);
        nb = 0; tc = -1; rd0 = '0; gr_ok = 1'b0;
        for (int c = 0; c < 20 && tc < 0; c++) begin
            cycle();
            if (obs_busy) nb++;
            if (obs_resp[0] && tc < 0) begin tc = nb; rd0 = obs_resp[32:1]; gr_ok = obs_err; end
        end
        chk("to_cycle", tc, TMO);
        chk("to_rdata", rd0, 32'hFFFF_FFFF);
        chk("to_err", gr_ok, 1'b1);
        cycle();
        chk("to_idle_after", obs_busy, 1'b0);
        chk("to_err_after", obs_err, 1'b0);
`endif

        // randomized traffic against the reference
        do_reset();
        lat = 0;
        rnd = 1'b1;
        for (int c = 0; c < 2000; c++) cycle();
        rnd = 1'b0;
        lat = 1;
        for (int c = 0; c < 30; c++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
